box_overlay_multi: RTL and testbench
====================================

Name: box_overlay_multi

Overview:
Streaming bounding-box overlay for the face-detect video path. Draws up to NUM_BOXES rectangular outlines of programmable thickness and per-box colour onto a raster RGB pixel stream, using a valid/ready handshake. Box geometry is double-buffered so that new detections take effect only at a frame boundary. It sits between the pixel source and the display or frame writer.

Parameters:
IMG_WIDTH, 768, active pixels per line
IMG_HEIGHT, 576, active lines per frame
NUM_BOXES, 4, number of independent box slots (1..8)
COORD_W, 10, coordinate/size width (must hold IMG_WIDTH-1 and IMG_HEIGHT-1)
PIX_W, 24, pixel width (RGB888)
THICK_W, 3, border thickness field width

Ports:
clk  in  1  clock
reset  in  1  reset; asynchronous, active-high
cfg_we  in  1  write one box slot to the pending bank
cfg_idx  in  3  slot index; writes with idx >= NUM_BOXES are ignored
cfg_en  in  1  slot enable
cfg_cx  in  COORD_W  box centre x
cfg_cy  in  COORD_W  box centre y
cfg_w  in  COORD_W  box width
cfg_h  in  COORD_W  box height
cfg_color  in  PIX_W  border colour
cfg_thick  in  THICK_W  border thickness in pixels; 0 is treated as 1
s_valid  in  1  input pixel valid
s_ready  out  1  input pixel accepted when s_valid and s_ready are both high
s_sof  in  1  start-of-frame marker on the first pixel
s_data  in  PIX_W  input pixel
m_valid  out  1  output pixel valid
m_ready  in  1  downstream ready
m_sof  out  1  start-of-frame, aligned with m_data
m_eol  out  1  last pixel of line, aligned with m_data
m_data  out  PIX_W  output pixel

Behaviour:
- Reset values:
  - m_valid=0, m_data=0, m_sof=0, m_eol=0.
  - Pixel counters x=0, y=0.
  - All pending and active slots: en=0, geometry=0, colour=0, thick=1.
- Handshake:
  - s_ready = !m_valid || m_ready.
  - An accepted beat loads the output register on the next clk edge, giving a latency of exactly 1 cycle.
  - With m_valid=1 and m_ready=0, the output holds stable. No beat is dropped or duplicated.
- Counters:
  - Advance only on accepted beats.
  - x wraps to 0 after IMG_WIDTH-1 and increments y.
  - y wraps to 0 after IMG_HEIGHT-1.
  - An accepted beat with s_sof=1 forces that pixel's coordinate to (0,0), regardless of the counters, so the block resyncs on a short or long frame.
- m_sof/m_eol:
  - m_sof=1 when the pixel coordinate is (0,0).
  - m_eol=1 when x=IMG_WIDTH-1.
- Config banks:
  - cfg_we writes the pending bank at any time.
  - The active bank is copied from the pending bank on the clk edge that accepts a pixel at coordinate (0,0).
  - That pixel is already drawn with the newly copied values.
  - A cfg_we in the same cycle as that copy lands in pending only. It is visible from the following frame.
- Edge computation (per slot, in COORD_W+1 bits, unsigned):
  - half_w = w>>1, half_h = h>>1.
  - L = max(cx-half_w, 0); R = min(cx+half_w, IMG_WIDTH-1).
  - T = max(cy-half_h, 0); B = min(cy+half_h, IMG_HEIGHT-1).
  - Edges are clamped, never wrapped.
  - t = max(thick, 1).
- Hit test (per slot, only when en=1):
  - The pixel must be inside L<=x<=R and T<=y<=B.
  - It must also satisfy at least one of: x<L+t, x>R-t, y<T+t, y>B-t. Each subtraction saturates at 0.
  - Boxes with width or height smaller than 2t render solid.
- Output selection: m_data = colour of the lowest-index hitting slot, otherwise s_data.
- Reset mid-frame: the output is discarded and counters return to (0,0). The stream must resync via s_sof.

Test Plan:
- Pass-through: no slots enabled, one 768x576 frame of incrementing data -> m_data equals s_data on every beat; m_sof only on the first beat; m_eol every 768 beats.
- Single box: slot0 cx=100, cy=50, w=20, h=10, colour FF0000, thick=1, configured before the frame -> red at x=90..110 on y=45 and y=55, red at x=90 and x=110 on y=45..55, all other pixels pass through.
- Thickness/priority: slot0 thick=3 colour FF0000; slot1 overlapping with colour 00FF00 -> border is 3 px wide; overlap pixels are red.
- Clamping: cx=5, cy=570, w=40, h=40 -> L=0, B=575, no wrap to the far edge, left and bottom edges drawn at 0 and 575.
- Double buffer: move slot0 mid-frame -> the current frame keeps the old box; the next frame shows the new box. A write in the same cycle as the (0,0) accept is deferred one frame.
- Backpressure/resync: random m_ready and s_valid gaps -> the output sequence is identical to the no-stall run. A 300-pixel short frame followed by s_sof -> the new frame is drawn from (0,0) correctly.

Source files
------------

// File: rtl/box_overlay_multi.sv
// Streaming bounding-box overlay: draws up to NUM_BOXES outlined rectangles onto a
// raster RGB stream. Box geometry is double-buffered and swapped at the frame origin.
module box_overlay_multi #(
  parameter int IMG_WIDTH  = 768,
  parameter int IMG_HEIGHT = 576,
  parameter int NUM_BOXES  = 4,
  parameter int COORD_W    = 10,
  parameter int PIX_W      = 24,
  parameter int THICK_W    = 3
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               cfg_we,
  input  logic [2:0]         cfg_idx,
  input  logic               cfg_en,
  input  logic [COORD_W-1:0] cfg_cx,
  input  logic [COORD_W-1:0] cfg_cy,
  input  logic [COORD_W-1:0] cfg_w,
  input  logic [COORD_W-1:0] cfg_h,
  input  logic [PIX_W-1:0]   cfg_color,
  input  logic [THICK_W-1:0] cfg_thick,
  input  logic               s_valid,
  output logic               s_ready,
  input  logic               s_sof,
  input  logic [PIX_W-1:0]   s_data,
  output logic               m_valid,
  input  logic               m_ready,
  output logic               m_sof,
  output logic               m_eol,
  output logic [PIX_W-1:0]   m_data
);

  localparam int CW1 = COORD_W + 1;
  localparam logic [CW1-1:0] X_MAX = CW1'(IMG_WIDTH - 1);
  localparam logic [CW1-1:0] Y_MAX = CW1'(IMG_HEIGHT - 1);

  typedef struct packed {
    logic               en;
    logic [COORD_W-1:0] cx;
    logic [COORD_W-1:0] cy;
    logic [COORD_W-1:0] w;
    logic [COORD_W-1:0] h;
    logic [PIX_W-1:0]   color;
    logic [THICK_W-1:0] thick;
  } slot_t;

  localparam slot_t SLOT_RST = '{en: 1'b0, cx: '0, cy: '0, w: '0, h: '0,
                                 color: '0, thick: THICK_W'(1)};

  slot_t              r_pend [NUM_BOXES];
  slot_t              r_act  [NUM_BOXES];
  logic [COORD_W-1:0] r_x;
  logic [COORD_W-1:0] r_y;
  logic               r_valid;
  logic               r_sof;
  logic               r_eol;
  logic [PIX_W-1:0]   r_data;

  logic               w_accept;
  logic               w_origin;
  logic               w_last_x;
  logic               w_last_y;
  logic [COORD_W-1:0] w_px;
  logic [COORD_W-1:0] w_py;
  logic [NUM_BOXES-1:0] w_hit;
  logic [PIX_W-1:0]   w_col [NUM_BOXES];
  logic [PIX_W-1:0]   w_pix;
  slot_t              w_wr;

  // Handshake: a beat transfers on any edge where valid and ready are both high;
  // a producer holds valid and data stable until it transfers.
  assign s_ready  = !r_valid || m_ready;
  assign w_accept = s_valid && s_ready;

  // s_sof resynchronises the raster position for this beat.
  assign w_px     = s_sof ? '0 : r_x;
  assign w_py     = s_sof ? '0 : r_y;
  assign w_origin = (w_px == '0) && (w_py == '0);
  assign w_last_x = (w_px == COORD_W'(IMG_WIDTH - 1));
  assign w_last_y = (w_py == COORD_W'(IMG_HEIGHT - 1));

  assign w_wr = '{en: cfg_en, cx: cfg_cx, cy: cfg_cy, w: cfg_w, h: cfg_h,
                  color: cfg_color, thick: cfg_thick};

  for (genvar g = 0; g < NUM_BOXES; g++) begin : g_slot
    slot_t          w_s;
    logic [CW1-1:0] w_cx, w_cy, w_hw, w_hh, w_tk, w_x, w_y;
    logic [CW1-1:0] w_rr, w_bb, w_l, w_r, w_t, w_b, w_r_in, w_b_in;

    // The origin pixel is drawn with the bank that is being copied on this edge.
    assign w_s    = w_origin ? r_pend[g] : r_act[g];
    assign w_cx   = CW1'(w_s.cx);
    assign w_cy   = CW1'(w_s.cy);
    assign w_hw   = CW1'(w_s.w >> 1);
    assign w_hh   = CW1'(w_s.h >> 1);
    assign w_tk   = (w_s.thick == '0) ? CW1'(1) : CW1'(w_s.thick);
    assign w_rr   = w_cx + w_hw;
    assign w_bb   = w_cy + w_hh;
    assign w_l    = (w_cx > w_hw) ? w_cx - w_hw : '0;
    assign w_t    = (w_cy > w_hh) ? w_cy - w_hh : '0;
    assign w_r    = (w_rr > X_MAX) ? X_MAX : w_rr;
    assign w_b    = (w_bb > Y_MAX) ? Y_MAX : w_bb;
    assign w_r_in = (w_r > w_tk) ? w_r - w_tk : '0;
    assign w_b_in = (w_b > w_tk) ? w_b - w_tk : '0;
    assign w_x    = CW1'(w_px);
    assign w_y    = CW1'(w_py);
    assign w_col[g] = w_s.color;
    assign w_hit[g] = w_s.en && (w_x >= w_l) && (w_x <= w_r) && (w_y >= w_t) && (w_y <= w_b) &&
                      ((w_x < w_l + w_tk) || (w_x > w_r_in) ||
                       (w_y < w_t + w_tk) || (w_y > w_b_in));
  end

  // Lowest-index hitting slot wins, so scan from the top down.
  always_comb begin
    w_pix = s_data;
    for (int i = NUM_BOXES - 1; i >= 0; i--) begin
      if (w_hit[i]) w_pix = w_col[i];
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < NUM_BOXES; i++) begin
        r_pend[i] <= SLOT_RST;
        r_act[i]  <= SLOT_RST;
      end
    end else begin
      for (int i = 0; i < NUM_BOXES; i++) begin
        if (cfg_we && (cfg_idx == 3'(i))) r_pend[i] <= w_wr;
        if (w_accept && w_origin) r_act[i] <= r_pend[i];
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_x     <= '0;
      r_y     <= '0;
      r_valid <= 1'b0;
      r_sof   <= 1'b0;
      r_eol   <= 1'b0;
      r_data  <= '0;
    end else if (w_accept) begin
      r_valid <= 1'b1;
      r_sof   <= w_origin;
      r_eol   <= w_last_x;
      r_data  <= w_pix;
      if (w_last_x) begin
        r_x <= '0;
        r_y <= w_last_y ? '0 : w_py + COORD_W'(1);
      end else begin
        r_x <= w_px + COORD_W'(1);
        r_y <= w_py;
      end
    end else if (m_ready) begin
      r_valid <= 1'b0;
    end
  end

  assign m_valid = r_valid;
  assign m_sof   = r_sof;
  assign m_eol   = r_eol;
  assign m_data  = r_data;

endmodule

// File: tb/tb_box_overlay_multi.sv
// Bench for box_overlay_multi on a reduced 100x60 raster: per-beat scoreboard fed by a
// geometric reference model, plus a table of hand-derived probe pixels per frame.
module tb_box_overlay_multi;
  localparam int W  = 100;
  localparam int H  = 60;
  localparam int NB = 4;
  localparam int CW = 10;
  localparam int PW = 24;
  localparam int TW = 3;
  localparam int EW = PW + 2 + 32;
  localparam logic [PW-1:0] RED = 24'hFF0000;
  localparam logic [PW-1:0] GRN = 24'h00FF00;
  localparam logic [PW-1:0] BLU = 24'h0000FF;

  logic          clk = 1'b0;
  logic          reset;
  logic          cfg_we;
  logic [2:0]    cfg_idx;
  logic          cfg_en;
  logic [CW-1:0] cfg_cx, cfg_cy, cfg_w, cfg_h;
  logic [PW-1:0] cfg_color;
  logic [TW-1:0] cfg_thick;
  logic          s_valid, s_ready, s_sof;
  logic [PW-1:0] s_data;
  logic          m_valid, m_ready, m_sof, m_eol;
  logic [PW-1:0] m_data;

  box_overlay_multi #(.IMG_WIDTH(W), .IMG_HEIGHT(H), .NUM_BOXES(NB), .COORD_W(CW),
                      .PIX_W(PW), .THICK_W(TW)) dut (
    .clk(clk), .reset(reset), .cfg_we(cfg_we), .cfg_idx(cfg_idx), .cfg_en(cfg_en),
    .cfg_cx(cfg_cx), .cfg_cy(cfg_cy), .cfg_w(cfg_w), .cfg_h(cfg_h),
    .cfg_color(cfg_color), .cfg_thick(cfg_thick),
    .s_valid(s_valid), .s_ready(s_ready), .s_sof(s_sof), .s_data(s_data),
    .m_valid(m_valid), .m_ready(m_ready), .m_sof(m_sof), .m_eol(m_eol), .m_data(m_data));

  always #5 clk = ~clk;

  typedef struct {
    logic en; int cx; int cy; int w; int h; logic [PW-1:0] color; int thick; int idx;
  } box_t;
  typedef struct {
    int frame; int x; int y; logic hit; logic [PW-1:0] col;
  } probe_t;

  box_t          pend [NB];
  box_t          act  [NB];
  box_t          no_cfg;
  int            mx, my;
  logic [EW-1:0] exp_q[$];
  logic [PW-1:0] in_frame [W*H];
  logic [PW-1:0] cap [W*H];
  probe_t        tbl[$];
  int            checks = 0;
  int            failures = 0;
  int            sof_seen, eol_seen;

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] want);
    checks++;
    if (got !== want) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, got, want);
    end
  endtask

  // ---------------- reference model ----------------
  function automatic int sat0(input int v);
    return (v < 0) ? 0 : v;
  endfunction

  function automatic logic [PW-1:0] model_pix(input int x, input int y, input logic [PW-1:0] d);
    for (int i = 0; i < NB; i++) begin
      int l, r, t, b, tk;
      l  = sat0(act[i].cx - act[i].w / 2);
      r  = (act[i].cx + act[i].w / 2 > W - 1) ? W - 1 : act[i].cx + act[i].w / 2;
      t  = sat0(act[i].cy - act[i].h / 2);
      b  = (act[i].cy + act[i].h / 2 > H - 1) ? H - 1 : act[i].cy + act[i].h / 2;
      tk = (act[i].thick == 0) ? 1 : act[i].thick;
      if (act[i].en && x >= l && x <= r && y >= t && y <= b &&
          (x < l + tk || x > sat0(r - tk) || y < t + tk || y > sat0(b - tk)))
        return act[i].color;
    end
    return d;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < NB; i++) begin
      pend[i] = '{1'b0, 0, 0, 0, 0, '0, 1, i};
      act[i]  = pend[i];
    end
    mx = 0;
    my = 0;
    exp_q.delete();
  endtask

  task automatic model_accept(input logic [PW-1:0] d, input logic sof);
    int px, py;
    logic org;
    px  = sof ? 0 : mx;
    py  = sof ? 0 : my;
    org = (px == 0) && (py == 0);
    if (org) for (int i = 0; i < NB; i++) act[i] = pend[i];
    in_frame[py*W+px] = d;
    exp_q.push_back({16'(py), 16'(px), org, px == W - 1, model_pix(px, py, d)});
    if (px == W - 1) begin
      mx = 0;
      my = (py == H - 1) ? 0 : py + 1;
    end else begin
      mx = px + 1;
      my = py;
    end
  endtask

  task automatic model_cfg(input box_t c);
    if (c.idx < NB) pend[c.idx] = c;
  endtask

  // ---------------- drivers ----------------
  task automatic step(input logic v, input logic [PW-1:0] d, input logic sof, input logic rdy,
                      input logic we, input box_t c, output logic acc);
    logic [EW-1:0] e;
    int ex, ey;
    @(negedge clk);
    s_valid = v; s_data = d; s_sof = sof; m_ready = rdy;
    cfg_we = we; cfg_idx = 3'(c.idx); cfg_en = c.en;
    cfg_cx = CW'(c.cx); cfg_cy = CW'(c.cy); cfg_w = CW'(c.w); cfg_h = CW'(c.h);
    cfg_color = c.color; cfg_thick = TW'(c.thick);
    #1;
    if (m_valid && m_ready) begin
      if (exp_q.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL extra_beat: got data %0h, expected no beat", m_data);
      end else begin
        e  = exp_q.pop_front();
        ex = int'(e[PW+17:PW+2]);
        ey = int'(e[PW+33:PW+18]);
        check($sformatf("beat_x%0d_y%0d", ex, ey), 64'({m_sof, m_eol, m_data}), 64'(e[PW+1:0]));
        cap[ey*W+ex] = m_data;
        sof_seen += int'(m_sof);
        eol_seen += int'(m_eol);
      end
    end
    acc = s_valid && s_ready;
    if (acc) model_accept(d, sof);
    if (we) model_cfg(c);
  endtask

  task automatic cfg_write(input int idx, input logic en, input int cx, input int cy,
                           input int w, input int h, input logic [PW-1:0] col, input int th);
    box_t c;
    logic acc;
    c = '{en, cx, cy, w, h, col, th, idx};
    step(1'b0, '0, 1'b0, 1'b1, 1'b1, c, acc);
  endtask

  function automatic box_t rand_box();
    box_t b;
    b.idx   = int'($urandom_range(7));
    b.en    = ($urandom_range(3) != 0);
    b.cx    = int'($urandom_range(W + 20));
    b.cy    = int'($urandom_range(H + 20));
    b.w     = int'($urandom_range(60));
    b.h     = int'($urandom_range(40));
    b.color = PW'($urandom);
    b.thick = int'($urandom_range(7));
    return b;
  endfunction

  task automatic send_pixel(input logic [PW-1:0] d, input logic sof, input int stall,
                            input logic we, input box_t c);
    logic acc;
    int tries;
    if (stall > 0)
      while (int'($urandom_range(99)) < stall)
        step(1'b0, PW'($urandom), 1'b0, int'($urandom_range(99)) >= stall, 1'b0, no_cfg, acc);
    tries = 0;
    do begin
      step(1'b1, d, sof, (stall > 0) ? (int'($urandom_range(99)) >= stall) : 1'b1, we, c, acc);
      tries++;
    end while (!acc && tries < 200);
    if (!acc) check("accept_timeout", 64'(acc), 64'(1));
  endtask

  task automatic send_range(input int first, input int last, input logic inc, input int stall,
                            input logic we_first, input box_t c_first, input logic rnd_we);
    for (int i = first; i <= last; i++) begin
      logic [PW-1:0] d;
      logic we;
      box_t c;
      d  = inc ? PW'(i) : PW'($urandom);
      we = 1'b0;
      c  = no_cfg;
      if (we_first && i == first) begin
        we = 1'b1;
        c  = c_first;
      end else if (rnd_we && $urandom_range(99) == 0) begin
        we = 1'b1;
        c  = rand_box();
      end
      send_pixel(d, i == 0, stall, we, c);
    end
  endtask

  task automatic drain();
    logic acc;
    int n;
    n = 0;
    while (exp_q.size() > 0 && n < 100) begin
      step(1'b0, '0, 1'b0, 1'b1, 1'b0, no_cfg, acc);
      n++;
    end
    check("drain_empty", 64'(exp_q.size()), 64'(0));
  endtask

  task automatic run_probes(input int frame);
    foreach (tbl[i]) begin
      if (tbl[i].frame == frame)
        check($sformatf("probe_f%0d_x%0d_y%0d", frame, tbl[i].x, tbl[i].y),
              64'(cap[tbl[i].y*W+tbl[i].x]),
              64'(tbl[i].hit ? tbl[i].col : in_frame[tbl[i].y*W+tbl[i].x]));
    end
  endtask

  task automatic disable_all();
    for (int i = 0; i < NB; i++) cfg_write(i, 1'b0, 0, 0, 0, 0, '0, 1);
  endtask

  initial begin
    #1500000;
    $display("FAIL watchdog: time limit reached before the end of the test");
    $fatal(1, "watchdog");
  end

  initial begin
    box_t c;
    no_cfg = '{1'b0, 0, 0, 0, 0, '0, 1, 0};
    // frame 1: single box L30 R50 T15 B25
    tbl.push_back('{1, 30, 15, 1, RED}); tbl.push_back('{1, 50, 15, 1, RED});
    tbl.push_back('{1, 40, 25, 1, RED}); tbl.push_back('{1, 30, 20, 1, RED});
    tbl.push_back('{1, 50, 20, 1, RED}); tbl.push_back('{1, 29, 15, 0, '0});
    tbl.push_back('{1, 51, 25, 0, '0});  tbl.push_back('{1, 31, 16, 0, '0});
    tbl.push_back('{1, 40, 20, 0, '0});  tbl.push_back('{1, 30, 14, 0, '0});
    tbl.push_back('{1, 30, 26, 0, '0});  tbl.push_back('{1, 49, 24, 0, '0});
    // frame 3: thick-3 red box over thin green box L40 R60 T20 B30
    tbl.push_back('{3, 32, 20, 1, RED}); tbl.push_back('{3, 33, 20, 0, '0});
    tbl.push_back('{3, 30, 17, 1, RED}); tbl.push_back('{3, 40, 18, 0, '0});
    tbl.push_back('{3, 40, 17, 1, RED}); tbl.push_back('{3, 48, 20, 1, RED});
    tbl.push_back('{3, 50, 20, 1, RED}); tbl.push_back('{3, 40, 21, 1, GRN});
    tbl.push_back('{3, 55, 30, 1, GRN}); tbl.push_back('{3, 55, 25, 0, '0});
    tbl.push_back('{3, 45, 23, 1, RED}); tbl.push_back('{3, 60, 25, 1, GRN});
    // frame 4: clamped box L0 R25 T35 B59
    tbl.push_back('{4, 0, 40, 1, BLU});  tbl.push_back('{4, 0, 59, 1, BLU});
    tbl.push_back('{4, 10, 59, 1, BLU}); tbl.push_back('{4, 25, 50, 1, BLU});
    tbl.push_back('{4, 10, 35, 1, BLU}); tbl.push_back('{4, 1, 50, 0, '0});
    tbl.push_back('{4, 10, 58, 0, '0});  tbl.push_back('{4, 99, 59, 0, '0});
    tbl.push_back('{4, 99, 40, 0, '0});  tbl.push_back('{4, 10, 34, 0, '0});
    tbl.push_back('{4, 26, 50, 0, '0});  tbl.push_back('{4, 40, 30, 0, '0});
    // frames 5/6/7: double-buffered moves
    tbl.push_back('{5, 15, 45, 1, RED}); tbl.push_back('{5, 25, 50, 1, RED});
    tbl.push_back('{5, 20, 40, 1, RED}); tbl.push_back('{5, 65, 45, 0, '0});
    tbl.push_back('{5, 70, 40, 0, '0});  tbl.push_back('{5, 20, 45, 0, '0});
    tbl.push_back('{6, 65, 45, 1, RED}); tbl.push_back('{6, 75, 50, 1, RED});
    tbl.push_back('{6, 15, 45, 0, '0});  tbl.push_back('{6, 40, 45, 0, '0});
    tbl.push_back('{6, 70, 45, 0, '0});
    tbl.push_back('{7, 40, 45, 1, RED}); tbl.push_back('{7, 50, 40, 1, RED});
    tbl.push_back('{7, 45, 40, 1, RED}); tbl.push_back('{7, 65, 45, 0, '0});
    tbl.push_back('{7, 15, 45, 0, '0});  tbl.push_back('{7, 45, 45, 0, '0});

    // clock/reset
    reset = 1'b1; s_valid = 1'b0; s_sof = 1'b0; s_data = '0; m_ready = 1'b0;
    cfg_we = 1'b0; cfg_idx = '0; cfg_en = 1'b0; cfg_cx = '0; cfg_cy = '0;
    cfg_w = '0; cfg_h = '0; cfg_color = '0; cfg_thick = '0;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    model_reset();
    #1;
    check("reset_m_valid", 64'(m_valid), 64'(0));
    check("reset_m_data", 64'(m_data), 64'(0));
    check("reset_m_sof", 64'(m_sof), 64'(0));
    check("reset_m_eol", 64'(m_eol), 64'(0));
    check("reset_s_ready", 64'(s_ready), 64'(1));

    // pass-through, incrementing data
    sof_seen = 0;
    eol_seen = 0;
    send_range(0, W*H-1, 1'b1, 0, 1'b0, no_cfg, 1'b0);
    drain();
    check("pass_sof_count", 64'(sof_seen), 64'(1));
    check("pass_eol_count", 64'(eol_seen), 64'(H));

    cfg_write(0, 1'b1, 40, 20, 20, 10, RED, 1);
    send_range(0, W*H-1, 1'b0, 0, 1'b0, no_cfg, 1'b0);
    drain();
    run_probes(1);

    cfg_write(0, 1'b1, 40, 20, 20, 10, RED, 3);
    cfg_write(1, 1'b1, 50, 25, 20, 10, GRN, 1);
    send_range(0, W*H-1, 1'b0, 0, 1'b0, no_cfg, 1'b0);
    drain();
    run_probes(3);

    cfg_write(1, 1'b0, 0, 0, 0, 0, '0, 1);
    cfg_write(0, 1'b1, 5, 55, 40, 40, BLU, 1);
    cfg_write(5, 1'b1, 50, 30, 20, 20, GRN, 1);
    send_range(0, W*H-1, 1'b0, 0, 1'b0, no_cfg, 1'b0);
    drain();
    run_probes(4);

    // move mid-frame, then write in the same cycle as the origin accept
    cfg_write(0, 1'b1, 20, 45, 10, 10, RED, 1);
    send_range(0, 2999, 1'b0, 0, 1'b0, no_cfg, 1'b0);
    cfg_write(0, 1'b1, 70, 45, 10, 10, RED, 1);
    send_range(3000, W*H-1, 1'b0, 0, 1'b0, no_cfg, 1'b0);
    drain();
    run_probes(5);
    c = '{1'b1, 45, 45, 10, 10, RED, 1, 0};
    send_range(0, W*H-1, 1'b0, 0, 1'b1, c, 1'b0);
    drain();
    run_probes(6);
    send_range(0, 4699, 1'b0, 0, 1'b0, no_cfg, 1'b0);
    drain();
    run_probes(7);

    // short 300-pixel frame, then a full frame resynced by s_sof
    cfg_write(0, 1'b1, 40, 20, 20, 10, RED, 1);
    send_range(0, 299, 1'b0, 0, 1'b0, no_cfg, 1'b0);
    send_range(0, W*H-1, 1'b0, 0, 1'b0, no_cfg, 1'b0);
    drain();
    run_probes(1);

    // random boxes, random config traffic and random stalls on both sides
    for (int i = 0; i < 10; i++) begin
      c = rand_box();
      cfg_write(c.idx, c.en, c.cx, c.cy, c.w, c.h, c.color, c.thick);
    end
    send_range(0, W*H-1, 1'b0, 35, 1'b0, no_cfg, 1'b1);
    send_range(0, 1499, 1'b0, 35, 1'b0, no_cfg, 1'b1);
    drain();

    // mid-frame reset: outputs cleared asynchronously, counters restart at the origin
    send_range(0, 2549, 1'b0, 0, 1'b0, no_cfg, 1'b0);
    s_valid = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    #1;
    check("midrst_m_valid", 64'(m_valid), 64'(0));
    check("midrst_m_data", 64'(m_data), 64'(0));
    @(negedge clk);
    reset = 1'b0;
    model_reset();
    sof_seen = 0;
    eol_seen = 0;
    send_range(1, 250, 1'b1, 0, 1'b0, no_cfg, 1'b0);
    drain();
    check("midrst_sof_count", 64'(sof_seen), 64'(1));
    check("midrst_eol_count", 64'(eol_seen), 64'(2));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
